// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: decode/execute hazard sources in,
// pipeline register enables and bubble loads out.
interface pipe_hazard_ctrl_if;
  logic [2:0] id_rs1;
  logic [2:0] id_rs2;
  logic       id_rs1_vld;
  logic       id_rs2_vld;
  logic       dx_rf_writeEn;
  logic [2:0] dx_rf_sel_out;
  logic       dx_memread;
  logic       dx_halt;
  logic       branch_taken;
  logic       imem_stall;
  logic       dmem_stall;
  logic       pc_en;
  logic       fd_en;
  logic       dx_en;
  logic       xm_en;
  logic       mw_en;
  logic       fd_flush;
  logic       dx_flush;
  logic       mw_flush;
  logic       halted;

  modport master (
    output id_rs1, id_rs2, id_rs1_vld, id_rs2_vld,
    output dx_rf_writeEn, dx_rf_sel_out, dx_memread,
    output dx_halt, branch_taken, imem_stall, dmem_stall,
    input  pc_en, fd_en, dx_en, xm_en, mw_en,
    input  fd_flush, dx_flush, mw_flush, halted
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_vld, id_rs2_vld,
    input  dx_rf_writeEn, dx_rf_sel_out, dx_memread,
    input  dx_halt, branch_taken, imem_stall, dmem_stall,
    output pc_en, fd_en, dx_en, xm_en, mw_en,
    output fd_flush, dx_flush, mw_flush, halted
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline:
// load-use, branch squash, memory stalls, halt drain.
module pipe_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_CYC - 1);

  state_t     state, state_nxt;
  logic [1:0] drain, drain_nxt;
  logic       load_use;
  logic       rs1_hit, rs2_hit;

  logic pc_en, fd_en, dx_en, xm_en, mw_en;
  logic fd_flush, dx_flush, mw_flush, halted;

  assign rs1_hit = bus.id_rs1_vld
                 & (bus.id_rs1 == bus.dx_rf_sel_out);
  assign rs2_hit = bus.id_rs2_vld
                 & (bus.id_rs2 == bus.dx_rf_sel_out);
  assign load_use = bus.dx_memread & bus.dx_rf_writeEn
                  & (rs1_hit | rs2_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      drain <= 2'd0;
    end else begin
      state <= state_nxt;
      drain <= drain_nxt;
    end
  end

  // Overlapping hazard sources resolve by rank, oldest stage first.
  always_comb begin
    state_nxt = state;
    drain_nxt = drain;
    pc_en     = 1'b0;
    fd_en     = 1'b0;
    dx_en     = 1'b0;
    xm_en     = 1'b0;
    mw_en     = 1'b0;
    fd_flush  = 1'b0;
    dx_flush  = 1'b0;
    mw_flush  = 1'b0;
    halted    = 1'b0;
    priority case (1'b1)
      rst: begin
      end
      state == HALTED: begin
        halted = 1'b1;
      end
      bus.dmem_stall: begin
        mw_en    = 1'b1;
        mw_flush = 1'b1;
      end
      state == DRAIN: begin
        dx_en    = 1'b1;
        dx_flush = 1'b1;
        xm_en    = 1'b1;
        mw_en    = 1'b1;
        if (drain == 2'd0) state_nxt = HALTED;
        else drain_nxt = drain - 2'd1;
      end
      bus.branch_taken: begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        dx_en    = 1'b1;
        xm_en    = 1'b1;
        mw_en    = 1'b1;
        fd_flush = 1'b1;
        dx_flush = 1'b1;
      end
      bus.dx_halt: begin
        dx_en     = 1'b1;
        dx_flush  = 1'b1;
        xm_en     = 1'b1;
        mw_en     = 1'b1;
        state_nxt = DRAIN;
        drain_nxt = DRAIN_INIT;
      end
      load_use: begin
        dx_en    = 1'b1;
        dx_flush = 1'b1;
        xm_en    = 1'b1;
        mw_en    = 1'b1;
      end
      bus.imem_stall: begin
        fd_en    = 1'b1;
        fd_flush = 1'b1;
        dx_en    = 1'b1;
        xm_en    = 1'b1;
        mw_en    = 1'b1;
      end
      default: begin
        pc_en = 1'b1;
        fd_en = 1'b1;
        dx_en = 1'b1;
        xm_en = 1'b1;
        mw_en = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state != HALTED && !pc_en
                 && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign bus.pc_en    = pc_en;
  assign bus.fd_en    = fd_en;
  assign bus.dx_en    = dx_en;
  assign bus.xm_en    = xm_en;
  assign bus.mw_en    = mw_en;
  assign bus.fd_flush = fd_flush;
  assign bus.dx_flush = dx_flush;
  assign bus.mw_flush = mw_flush;
  assign bus.halted   = halted;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It drives the enable and bubble-insert (flush) inputs of the PC and of the F/D, D/X, X/M and M/W pipeline registers. It resolves load-use hazards, taken branches, instruction/data memory stalls and halt drain, and keeps a saturating stall-cycle counter. It sits beside the pipeline registers and holds no datapath state.

## Interface
Parameters:
- CNT_W, 16, width of stall_cycles
- DRAIN_CYC, 2, cycles for a halt in X to retire through M and W

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  3 each  source register numbers of the instruction in decode
- id_rs1_vld, id_rs2_vld  in  1 each  source is actually read
- dx_rf_writeEn  in  1  instruction in X writes the register file
- dx_rf_sel_out  in  3  destination register of the instruction in X
- dx_memread  in  1  instruction in X is a load
- dx_halt  in  1  instruction in X is HALT
- branch_taken  in  1  branch/jump resolved taken in X
- imem_stall  in  1  instruction memory not ready this cycle
- dmem_stall  in  1  data memory busy; M must hold
- pc_en  out  1  PC register enable
- fd_en, dx_en, xm_en, mw_en  out  1 each  pipeline register enables
- fd_flush, dx_flush, mw_flush  out  1 each  load bubble (all control zero) on this edge
- halted  out  1  processor halted
- stall_cycles  out  CNT_W  count of cycles with pc_en=0, excluding the HALTED state

## Operation
- FSM states: RUN, DRAIN, HALTED. The drain counter is 2 bits wide.
- Outputs are combinational from state and inputs. Evaluate the following rules in priority order; the first match applies.
- rst=1: all enables 0, all flushes 0, halted=0. Next state RUN, drain counter 0, stall_cycles 0.
- HALTED: all enables 0, flushes 0, halted=1. The block leaves HALTED only on rst.
- dmem_stall=1 (RUN or DRAIN):
  - pc_en, fd_en, dx_en, xm_en = 0.
  - mw_en=1 with mw_flush=1, so W receives a bubble.
  - The drain counter does not change.
- RUN with branch_taken=1:
  - All enables 1; fd_flush=1 and dx_flush=1.
  - The PC loads the target even if imem_stall=1.
  - Load-use and dx_halt are ignored: the halt is younger than the branch and is squashed.
- RUN with dx_halt=1:
  - pc_en=0, fd_en=0, dx_flush=1; xm_en and mw_en are 1.
  - Next state DRAIN, drain counter = DRAIN_CYC-1.
- RUN with load-use hazard, defined as dx_memread & dx_rf_writeEn & ((id_rs1_vld & id_rs1==dx_rf_sel_out) | (id_rs2_vld & id_rs2==dx_rf_sel_out)):
  - pc_en=0, fd_en=0, dx_en=1 with dx_flush=1; xm_en and mw_en are 1.
  - Exactly one bubble per hazard: on the next cycle the load is in M and forwarding covers the dependence.
- RUN with imem_stall=1: pc_en=0, fd_en=1 with fd_flush=1; dx_en, xm_en and mw_en are 1.
- RUN otherwise: all enables 1, all flushes 0.
- DRAIN (no dmem_stall):
  - pc_en=0, fd_en=0, dx_flush=1; xm_en and mw_en are 1.
  - branch_taken and imem_stall are ignored.
  - If the counter is 0, next state is HALTED; otherwise the counter decrements.
- stall_cycles increments on every edge with rst=0, state not HALTED and pc_en=0. It saturates at all-ones.

## Timing
- Zero-cycle latency from inputs to enable/flush outputs. Next-state logic and stall_cycles update on the rising edge.
- A load-use hazard costs exactly 1 cycle. A taken branch costs 2 bubbles (F/D and D/X). A dmem stall of N cycles freezes PC, F/D, D/X and X/M for exactly N cycles.
- Halt: dx_halt seen at edge k gives halted=1 at edge k+DRAIN_CYC, plus any dmem_stall cycles that occur during DRAIN.
- If rst is asserted in DRAIN or HALTED, state is RUN after that edge and outputs follow the rst rule during it.
- Output values while rst=1: pc_en=fd_en=dx_en=xm_en=mw_en=0, all flushes=0, halted=0. After the reset edge: stall_cycles=0.

## Test plan
- Load-use: LD to R3 in X, decode reads R3 (rs1_vld=1). Required: one cycle with pc_en=0, fd_en=0, dx_flush=1; next cycle all enables 1; stall_cycles=1.
- Branch vs. hazard: branch_taken=1, load-use and imem_stall all active in the same cycle. Required: pc_en=1, fd_flush=1, dx_flush=1; stall_cycles unchanged.
- Dmem stall: dmem_stall held 3 cycles. Required: PC/F/D/D/X/X/M enables 0 for exactly 3 cycles, mw_flush=1 each cycle, stall_cycles +3.
- Halt drain: dx_halt=1 with a 1-cycle dmem_stall during DRAIN (DRAIN_CYC=2). Required: halted=1 exactly 3 edges after dx_halt; outputs then frozen until rst.
- Saturation: hold imem_stall with stall_cycles preloaded near the top (CNT_W=4 build, 20 cycles). Required: counter sticks at 4'hF.
- Reset in DRAIN: assert rst 1 cycle. Required: all outputs 0 during reset, then state RUN with normal enables and stall_cycles=0.
